// File: rtl/cvxif_issue_arbiter.sv
// rtl/cvxif_issue_arbiter.sv - round-robin sharing of one CV-X-IF coprocessor among NrPorts cores
// Issue ids are remapped to slot tags; results are routed back through the slot table.
module cvxif_issue_arbiter #(
  parameter int NrPorts        = 2,
  parameter int IdWidth        = 3,
  parameter int MaxOutstanding = 4,
  parameter int DataWidth      = 64,
  parameter int TagWidth       = $clog2(MaxOutstanding)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NrPorts-1:0]         req_valid_i,
  input  logic [NrPorts*32-1:0]      req_instr_i,
  input  logic [NrPorts*IdWidth-1:0] req_id_i,
  output logic [NrPorts-1:0]         req_ready_o,
  output logic [NrPorts-1:0]         req_accept_o,
  output logic                       cop_valid_o,
  output logic [31:0]                cop_instr_o,
  output logic [TagWidth-1:0]        cop_id_o,
  input  logic                       cop_ready_i,
  input  logic                       cop_accept_i,
  input  logic                       cop_res_valid_i,
  input  logic [TagWidth-1:0]        cop_res_id_i,
  input  logic [DataWidth-1:0]       cop_res_data_i,
  output logic                       cop_res_ready_o,
  output logic [NrPorts-1:0]         res_valid_o,
  output logic [IdWidth-1:0]         res_id_o,
  output logic [DataWidth-1:0]       res_data_o,
  input  logic [NrPorts-1:0]         res_ready_i,
  output logic                       err_o
);

  localparam int PortWidth = $clog2(NrPorts);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                state_q, state_d;
  logic [PortWidth-1:0]  rr_q, gnt_q, gnt_d;
  logic [TagWidth-1:0]   tag_q, tag_d;
  logic [MaxOutstanding-1:0] slot_used_q;
  logic [PortWidth-1:0]  slot_port_q [MaxOutstanding];
  logic [IdWidth-1:0]    slot_id_q   [MaxOutstanding];
  logic                  err_q;

  logic                  free_found, req_found, alloc, release_slot, res_hit;
  logic [TagWidth-1:0]   free_tag;
  logic [PortWidth-1:0]  pick;
  logic [PortWidth-1:0]  res_port;

  // Descending scans so the last hit is the lowest free slot / first port from rr_q.
  always_comb begin
    free_found = 1'b0;
    free_tag   = '0;
    for (int i = MaxOutstanding - 1; i >= 0; i--) begin
      if (!slot_used_q[i]) begin
        free_found = 1'b1;
        free_tag   = TagWidth'(i);
      end
    end
    req_found = 1'b0;
    pick      = '0;
    for (int i = NrPorts - 1; i >= 0; i--) begin
      if (req_valid_i[(int'(rr_q) + i) % NrPorts]) begin
        req_found = 1'b1;
        pick      = PortWidth'((int'(rr_q) + i) % NrPorts);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    tag_d        = tag_q;
    alloc        = 1'b0;
    cop_valid_o  = 1'b0;
    cop_instr_o  = '0;
    cop_id_o     = '0;
    req_ready_o  = '0;
    req_accept_o = '0;
    case (state_q)
      IDLE: begin
        if (free_found && req_found) begin
          state_d = LOCKED;
          gnt_d   = pick;
          tag_d   = free_tag;
        end
      end
      LOCKED: begin
        cop_valid_o = 1'b1;
        cop_instr_o = req_instr_i[int'(gnt_q)*32 +: 32];
        cop_id_o    = tag_q;
        if (cop_ready_i) begin
          req_ready_o[gnt_q]  = 1'b1;
          req_accept_o[gnt_q] = cop_accept_i;
          alloc               = cop_accept_i;
          state_d             = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Unallocated tags are swallowed: ready follows valid so the coprocessor never stalls on them.
  assign res_hit  = slot_used_q[cop_res_id_i];
  assign res_port = slot_port_q[cop_res_id_i];

  always_comb begin
    res_valid_o     = '0;
    res_id_o        = '0;
    res_data_o      = '0;
    cop_res_ready_o = cop_res_valid_i;
    release_slot    = 1'b0;
    if (res_hit) begin
      res_valid_o[res_port] = cop_res_valid_i;
      res_id_o              = slot_id_q[cop_res_id_i];
      res_data_o            = cop_res_data_i;
      cop_res_ready_o       = res_ready_i[res_port];
      release_slot          = cop_res_valid_i && res_ready_i[res_port];
    end
  end

  assign err_o = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      gnt_q       <= '0;
      tag_q       <= '0;
      slot_used_q <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < MaxOutstanding; i++) begin
        slot_port_q[i] <= '0;
        slot_id_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      tag_q   <= tag_d;
      if (state_q == LOCKED && cop_ready_i) begin
        rr_q <= PortWidth'((int'(gnt_q) + 1) % NrPorts);
      end
      if (alloc) begin
        slot_used_q[tag_q] <= 1'b1;
        slot_port_q[tag_q] <= gnt_q;
        slot_id_q[tag_q]   <= req_id_i[int'(gnt_q)*IdWidth +: IdWidth];
      end
      if (release_slot) begin
        slot_used_q[cop_res_id_i] <= 1'b0;
      end
      if (cop_res_valid_i && !res_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  // A result cannot target the slot whose issue handshake is completing this cycle.
  a_no_res_on_issuing_tag: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(state_q == LOCKED && cop_ready_i && cop_res_valid_i && cop_res_id_i == tag_q));

endmodule

// File: tb/tb_cvxif_issue_arbiter.sv
// tb/tb_cvxif_issue_arbiter.sv - scoreboard bench for cvxif_issue_arbiter
module tb_cvxif_issue_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [63:0] req_instr;
  logic [5:0]  req_id;
  logic [1:0]  req_ready_o, req_accept_o;
  logic        cop_valid_o;
  logic [31:0] cop_instr_o;
  logic [1:0]  cop_id_o;
  logic        cop_ready_i, cop_accept_i;
  logic        cop_res_valid_i;
  logic [1:0]  cop_res_id_i;
  logic [63:0] cop_res_data_i;
  logic        cop_res_ready_o;
  logic [1:0]  res_valid_o;
  logic [2:0]  res_id_o;
  logic [63:0] res_data_o;
  logic [1:0]  res_ready_i;
  logic        err_o;

  always #5 clk = ~clk;

  cvxif_issue_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_instr_i(req_instr), .req_id_i(req_id),
    .req_ready_o(req_ready_o), .req_accept_o(req_accept_o),
    .cop_valid_o(cop_valid_o), .cop_instr_o(cop_instr_o), .cop_id_o(cop_id_o),
    .cop_ready_i(cop_ready_i), .cop_accept_i(cop_accept_i),
    .cop_res_valid_i(cop_res_valid_i), .cop_res_id_i(cop_res_id_i),
    .cop_res_data_i(cop_res_data_i), .cop_res_ready_o(cop_res_ready_o),
    .res_valid_o(res_valid_o), .res_id_o(res_id_o), .res_data_o(res_data_o),
    .res_ready_i(res_ready_i), .err_o(err_o)
  );

  typedef struct {int port; logic [1:0] tag; logic [31:0] instr; logic acc;} iss_t;
  typedef struct {int port; logic [2:0] id; logic [63:0] data;} res_t;

  iss_t iss_q[$];
  res_t res_q[$];
  iss_t ie;
  res_t re;
  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input int p, input int k);
    return 32'hC000_0000 | 32'(p << 8) | 32'(k);
  endfunction

  // Monitor samples late in the low phase, after all stimulus has settled.
  always begin
    @(negedge clk);
    #4;
    if (rst_n) begin
      if (cop_valid_o && cop_ready_i) begin
        if (iss_q.size() == 0) begin
          check_eq("iss_unexpected_tag", 64'(cop_id_o), 64'hDEAD);
        end else begin
          ie = iss_q.pop_front();
          check_eq("iss_port", 64'(req_ready_o), 64'd1 << ie.port);
          check_eq("iss_accept", 64'(req_accept_o), ie.acc ? (64'd1 << ie.port) : 64'd0);
          check_eq("iss_tag", 64'(cop_id_o), 64'(ie.tag));
          check_eq("iss_instr", 64'(cop_instr_o), 64'(ie.instr));
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (res_valid_o[p] && res_ready_i[p]) begin
          if (res_q.size() == 0) begin
            check_eq("res_unexpected_id", 64'(res_id_o), 64'hDEAD);
          end else begin
            re = res_q.pop_front();
            check_eq("res_port", 64'(res_valid_o), 64'd1 << re.port);
            check_eq("res_id", 64'(res_id_o), 64'(re.id));
            check_eq("res_data", res_data_o, re.data);
          end
        end
      end
    end
  end

  task automatic issue(input int p, input logic [2:0] id, input logic [31:0] instr,
                       input logic acc, input logic [1:0] tag);
    bit got = 0;
    cop_accept_i = acc;
    req_id[p*3 +: 3] = id;
    req_instr[p*32 +: 32] = instr;
    req_valid[p] = 1'b1;
    iss_q.push_back('{p, tag, instr, acc});
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (req_ready_o[p]) got = 1;
      else @(negedge clk);
    end
    if (!got) check_eq("issue_timeout", 64'd0, 64'd1);
    @(negedge clk);
    req_valid[p] = 1'b0;
  endtask

  task automatic result(input logic [1:0] tag, input logic [63:0] data, input int p,
                        input logic [2:0] id);
    res_q.push_back('{p, id, data});
    res_ready_i = 2'b11;
    cop_res_valid_i = 1'b1;
    cop_res_id_i = tag;
    cop_res_data_i = data;
    @(negedge clk);
    cop_res_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int k[2];
    int n;
    logic [1:0] upd;
    rst_n = 1'b0; req_valid = '0; req_instr = '0; req_id = '0;
    cop_ready_i = 1'b0; cop_accept_i = 1'b0; cop_res_valid_i = 1'b0;
    cop_res_id_i = '0; cop_res_data_i = '0; res_ready_i = '0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_cop_valid", 64'(cop_valid_o), 64'd0);
    check_eq("rst_req_ready", 64'(req_ready_o), 64'd0);
    check_eq("rst_res_valid", 64'(res_valid_o), 64'd0);
    check_eq("rst_cop_res_ready", 64'(cop_res_ready_o), 64'd0);
    check_eq("rst_err", 64'(err_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single request, then its result
    cop_ready_i = 1'b1; cop_accept_i = 1'b1;
    req_id[2:0] = 3'd5; req_instr[31:0] = 32'h1234_5005; req_valid[0] = 1'b1;
    iss_q.push_back('{0, 2'd0, 32'h1234_5005, 1'b1});
    #1 check_eq("single_lat0", 64'(cop_valid_o), 64'd0);
    @(negedge clk); #1;
    check_eq("single_valid", 64'(cop_valid_o), 64'd1);
    check_eq("single_tag", 64'(cop_id_o), 64'd0);
    check_eq("single_ready", 64'(req_ready_o), 64'b01);
    check_eq("single_accept", 64'(req_accept_o), 64'b01);
    @(negedge clk);
    req_valid = '0;
    res_ready_i = 2'b11;
    res_q.push_back('{0, 3'd5, 64'hABCD});
    cop_res_valid_i = 1'b1; cop_res_id_i = 2'd0; cop_res_data_i = 64'hABCD;
    #1 check_eq("single_res_valid", 64'(res_valid_o), 64'b01);
    @(negedge clk);
    cop_res_valid_i = 1'b0;
    issue(1, 3'd2, 32'h0000_2222, 1'b1, 2'd0);
    result(2'd0, 64'h55, 1, 3'd2);

    // fairness: both ports stream back to back until the table fills
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    k[0] = 0; k[1] = 0;
    for (int p = 0; p < 2; p++) begin
      req_instr[p*32 +: 32] = mk_instr(p, 0);
      req_id[p*3 +: 3] = 3'(p * 4);
    end
    iss_q.push_back('{0, 2'd0, mk_instr(0, 0), 1'b1});
    iss_q.push_back('{1, 2'd1, mk_instr(1, 0), 1'b1});
    iss_q.push_back('{0, 2'd2, mk_instr(0, 1), 1'b1});
    iss_q.push_back('{1, 2'd3, mk_instr(1, 1), 1'b1});
    cop_ready_i = 1'b1; cop_accept_i = 1'b1; req_valid = 2'b11;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      #1;
      upd = req_ready_o;
      if (upd != 2'b00) n++;
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (upd[p]) begin
          k[p]++;
          req_instr[p*32 +: 32] = mk_instr(p, k[p]);
          req_id[p*3 +: 3] = 3'(p * 4 + k[p]);
        end
      end
    end
    check_eq("fair_count", 64'(n), 64'd4);
    req_valid[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_eq("full_req_ready", 64'(req_ready_o), 64'd0);
      check_eq("full_cop_valid", 64'(cop_valid_o), 64'd0);
      @(negedge clk);
    end
    iss_q.push_back('{0, 2'd2, mk_instr(0, 2), 1'b1});
    result(2'd2, 64'h2222_0000, 0, 3'd1);
    #1 check_eq("refill_lat1", 64'(cop_valid_o), 64'd0);
    @(negedge clk); #1;
    check_eq("refill_lat2", 64'(cop_valid_o), 64'd1);
    check_eq("refill_tag", 64'(cop_id_o), 64'd2);
    @(negedge clk);
    req_valid = '0;
    result(2'd0, 64'h1000, 0, 3'd0);
    // result backpressure on tag 1 keeps the slot allocated
    cop_res_valid_i = 1'b1; cop_res_id_i = 2'd1; cop_res_data_i = 64'h1111; res_ready_i = 2'b00;
    #1;
    check_eq("bp_res_valid", 64'(res_valid_o), 64'b10);
    check_eq("bp_cop_res_ready", 64'(cop_res_ready_o), 64'd0);
    @(negedge clk); #1;
    check_eq("bp_res_held", 64'(res_valid_o), 64'b10);
    cop_res_valid_i = 1'b0;
    result(2'd1, 64'h1111, 1, 3'd4);
    result(2'd3, 64'h3333, 1, 3'd5);
    result(2'd2, 64'h4444, 0, 3'd2);
    check_eq("drain_err", 64'(err_o), 64'd0);

    // reject consumes no slot
    issue(1, 3'd6, 32'h0000_6666, 1'b0, 2'd0);
    issue(0, 3'd7, 32'h0000_7777, 1'b1, 2'd0);
    result(2'd0, 64'h7777, 0, 3'd7);

    // issue backpressure: payload stable while cop_ready_i is low
    cop_ready_i = 1'b0; cop_accept_i = 1'b1;
    req_instr[31:0] = 32'h0BAD_F00D; req_id[2:0] = 3'd3; req_valid[0] = 1'b1;
    iss_q.push_back('{0, 2'd0, 32'h0BAD_F00D, 1'b1});
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq("stall_instr", 64'(cop_instr_o), 64'h0BAD_F00D);
      check_eq("stall_tag", 64'(cop_id_o), 64'd0);
      check_eq("stall_req_ready", 64'(req_ready_o), 64'd0);
      @(negedge clk);
    end
    cop_ready_i = 1'b1;
    #1 check_eq("stall_release", 64'(req_ready_o), 64'b01);
    @(negedge clk);
    req_valid = '0;
    result(2'd0, 64'hF00D, 0, 3'd3);

    // unallocated tag
    cop_res_valid_i = 1'b1; cop_res_id_i = 2'd3; cop_res_data_i = 64'h9; res_ready_i = 2'b11;
    #1;
    check_eq("unalloc_ready", 64'(cop_res_ready_o), 64'd1);
    check_eq("unalloc_res_valid", 64'(res_valid_o), 64'd0);
    @(negedge clk);
    cop_res_valid_i = 1'b0;
    #1 check_eq("unalloc_err", 64'(err_o), 64'd1);
    repeat (3) @(negedge clk);
    #1 check_eq("err_sticky", 64'(err_o), 64'd1);

    // reset while LOCKED on port 1
    cop_ready_i = 1'b0; req_valid[1] = 1'b1;
    @(negedge clk);
    #1 check_eq("locked_before_rst", 64'(cop_valid_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_cop_valid", 64'(cop_valid_o), 64'd0);
    check_eq("rst_mid_err", 64'(err_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; req_valid = '0;
    cop_res_valid_i = 1'b1; cop_res_id_i = 2'd0;
    #1 check_eq("stale_res_ready", 64'(cop_res_ready_o), 64'd1);
    @(negedge clk);
    cop_res_valid_i = 1'b0;
    #1 check_eq("stale_err", 64'(err_o), 64'd1);
    // rr_q back at 0: port 0 wins when both request
    cop_ready_i = 1'b1; cop_accept_i = 1'b1;
    req_instr[31:0] = 32'hAAAA_0000;
    iss_q.push_back('{0, 2'd0, 32'hAAAA_0000, 1'b1});
    req_valid = 2'b11;
    @(negedge clk);
    #1 check_eq("rst_rr_grant", 64'(req_ready_o), 64'b01);
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);

    check_eq("iss_q_left", 64'(iss_q.size()), 64'd0);
    check_eq("res_q_left", 64'(res_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
